// File: rtl/mem_store_merge.sv
// Store-side merge unit for the multicycle MIPS datapath: turns SW/SH/SB requests
// into word writes, using read-modify-write for sub-word stores against a word-only memory.
module mem_store_merge #(
    parameter int AW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [2:0]    req_op_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [31:0]   req_data_i,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] mem_addr_o,
    output logic          mem_rd_o,
    input  logic [31:0]   mem_rdata_i,
    input  logic          mem_rvalid_i,
    output logic          mem_wr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic          mem_wack_i,
    output logic [3:0]    mem_be_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [2:0] OP_SW = 3'b000;
    localparam logic [2:0] OP_SH = 3'b001;
    localparam logic [2:0] OP_SB = 3'b010;

    logic [1:0]    state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          reqIllegal;
    logic          reqMisaligned;
    logic [31:0]   mergedWord;

    assign reqIllegal    = (req_op_i != OP_SW) && (req_op_i != OP_SH) && (req_op_i != OP_SB);
    assign reqMisaligned = ((req_op_i == OP_SW) && (req_addr_i[1:0] != 2'b00)) ||
                           ((req_op_i == OP_SH) && req_addr_i[0]);

    // Splice the latched store data into the word just read back from memory.
    always_comb begin
        mergedWord = mem_rdata_i;
        if (op_q == OP_SH) begin
            if (addr_q[1]) begin
                mergedWord = {data_q[15:0], mem_rdata_i[15:0]};
            end else begin
                mergedWord = {mem_rdata_i[31:16], data_q[15:0]};
            end
        end else begin
            case (addr_q[1:0])
                2'd0:    mergedWord = {mem_rdata_i[31:8], data_q[7:0]};
                2'd1:    mergedWord = {mem_rdata_i[31:16], data_q[7:0], mem_rdata_i[7:0]};
                2'd2:    mergedWord = {mem_rdata_i[31:24], data_q[7:0], mem_rdata_i[15:0]};
                default: mergedWord = {data_q[7:0], mem_rdata_i[23:0]};
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d   = req_op_i;
                    addr_d = req_addr_i;
                    data_d = req_data_i;
                    if (reqIllegal || reqMisaligned) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else if (req_op_i == OP_SW) begin
                        err_d   = 1'b0;
                        wdata_d = req_data_i;
                        state_d = WR;
                    end else begin
                        err_d   = 1'b0;
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (mem_rvalid_i) begin
                    wdata_d = mergedWord;
                    state_d = WR;
                end
            end
            WR: begin
                if (mem_wack_i) begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            op_q    <= OP_SW;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
        end
    end

    // Lane mask is forced to zero in IDLE so it reads clean straight after reset.
    always_comb begin
        mem_be_o = 4'b0000;
        if (state_q != IDLE) begin
            case (op_q)
                OP_SW:   mem_be_o = 4'b1111;
                OP_SH:   mem_be_o = addr_q[1] ? 4'b1100 : 4'b0011;
                OP_SB:   mem_be_o = 4'b0001 << addr_q[1:0];
                default: mem_be_o = 4'b0000;
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign done_o      = (state_q == RESP);
    assign err_o       = (state_q == RESP) && err_q;
    assign mem_rd_o    = (state_q == RD);
    assign mem_wr_o    = (state_q == WR);
    assign mem_wdata_o = wdata_q;
    assign mem_addr_o  = {addr_q[AW-1:2], 2'b00};

endmodule

// File: tb/tb_mem_store_merge.sv
// Directed bench for mem_store_merge: a wait-state memory responder plus hand-computed
// expectations for each store kind, error path, reset abort and back-to-back traffic.
module tb_mem_store_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic [2:0]  reqOp;
    logic [31:0] reqAddr;
    logic [31:0] reqData;
    logic        done;
    logic        err;
    logic [31:0] memAddr;
    logic        memRd;
    logic [31:0] memRdata;
    logic        memRvalid;
    logic        memWr;
    logic [31:0] memWdata;
    logic        memWack;
    logic [3:0]  memBe;

    int rdWait = 0;
    int wrWait = 0;
    int rdCnt = 0;
    int wrCnt = 0;
    logic forceAck = 1'b0;

    int nAsserts = 0;
    int nFails = 0;

    int rdCycles, wrCycles, doneCount, doneCycle, readyCycle;
    logic overlap, errSeen;
    logic [31:0] wrAddr, wrData;
    logic [3:0]  wrBe;

    always #5 clk = ~clk;

    mem_store_merge #(.AW(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_op_i    (reqOp),
        .req_addr_i  (reqAddr),
        .req_data_i  (reqData),
        .done_o      (done),
        .err_o       (err),
        .mem_addr_o  (memAddr),
        .mem_rd_o    (memRd),
        .mem_rdata_i (memRdata),
        .mem_rvalid_i(memRvalid),
        .mem_wr_o    (memWr),
        .mem_wdata_o (memWdata),
        .mem_wack_i  (memWack),
        .mem_be_o    (memBe)
    );

    // Memory responder: answers after a programmable number of strobe cycles.
    assign memRvalid = (memRd && (rdCnt >= rdWait)) || forceAck;
    assign memWack   = (memWr && (wrCnt >= wrWait)) || forceAck;

    always @(posedge clk) begin
        rdCnt <= memRd ? rdCnt + 1 : 0;
        wrCnt <= memWr ? wrCnt + 1 : 0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request from an IDLE cycle and record strobes/response until ready returns.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] rdata, input int rW, input int wW);
        memRdata   = rdata;
        rdWait     = rW;
        wrWait     = wW;
        reqOp      = op;
        reqAddr    = addr;
        reqData    = data;
        reqValid   = 1'b1;
        rdCycles   = 0;
        wrCycles   = 0;
        doneCount  = 0;
        doneCycle  = 0;
        readyCycle = 0;
        overlap    = 1'b0;
        errSeen    = 1'b0;
        wrAddr     = '0;
        wrData     = '0;
        wrBe       = '0;
        @(posedge clk); #1;
        reqValid = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (memRd) rdCycles++;
            if (memWr) begin
                if (wrCycles == 0) begin
                    wrAddr = memAddr;
                    wrData = memWdata;
                    wrBe   = memBe;
                end
                wrCycles++;
            end
            if (memRd && memWr) overlap = 1'b1;
            if (done) begin
                doneCount++;
                doneCycle = cyc;
                errSeen   = err;
            end
            if (reqReady && doneCount > 0) begin
                readyCycle = cyc;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    int accepts, dones, lastAccept;
    logic gapBad;

    initial begin
        rst      = 1'b1;
        reqValid = 1'b0;
        reqOp    = 3'b000;
        reqAddr  = '0;
        reqData  = '0;
        memRdata = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        checkOutput("rst_ready", {31'b0, reqReady}, 32'd1);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_strobes", {30'b0, memRd, memWr}, 32'd0);
        checkOutput("rst_wdata", memWdata, 32'h0);
        checkOutput("rst_addr", memAddr, 32'h0);
        checkOutput("rst_be", {28'b0, memBe}, 32'h0);

        // Stray acknowledges while idle must not move the FSM.
        forceAck = 1'b1;
        @(posedge clk); #1;
        forceAck = 1'b0;
        checkOutput("idle_ack_ready", {31'b0, reqReady}, 32'd1);
        checkOutput("idle_ack_done", {31'b0, done}, 32'd0);

        applyStimulus(3'b000, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
        checkOutput("sw_rd", rdCycles, 0);
        checkOutput("sw_wr", wrCycles, 1);
        checkOutput("sw_addr", wrAddr, 32'h100);
        checkOutput("sw_wdata", wrData, 32'hDEADBEEF);
        checkOutput("sw_be", {28'b0, wrBe}, 32'hF);
        checkOutput("sw_done_cyc", doneCycle, 2);
        checkOutput("sw_err", {31'b0, errSeen}, 32'd0);
        checkOutput("sw_ready_cyc", readyCycle, 3);

        applyStimulus(3'b010, 32'h203, 32'h000000AA, 32'h11223344, 0, 0);
        checkOutput("sb3_rd", rdCycles, 1);
        checkOutput("sb3_wr", wrCycles, 1);
        checkOutput("sb3_addr", wrAddr, 32'h200);
        checkOutput("sb3_wdata", wrData, 32'hAA223344);
        checkOutput("sb3_be", {28'b0, wrBe}, 32'h8);
        checkOutput("sb3_done_cyc", doneCycle, 3);
        checkOutput("sb3_ready_cyc", readyCycle, 4);

        applyStimulus(3'b010, 32'h200, 32'h000000AA, 32'h11223344, 0, 0);
        checkOutput("sb0_wdata", wrData, 32'h112233AA);
        checkOutput("sb0_be", {28'b0, wrBe}, 32'h1);
        applyStimulus(3'b010, 32'h201, 32'h000000AA, 32'h11223344, 0, 0);
        checkOutput("sb1_wdata", wrData, 32'h1122AA44);
        checkOutput("sb1_be", {28'b0, wrBe}, 32'h2);
        applyStimulus(3'b010, 32'h202, 32'h000000AA, 32'h11223344, 0, 0);
        checkOutput("sb2_wdata", wrData, 32'h11AA3344);
        checkOutput("sb2_be", {28'b0, wrBe}, 32'h4);

        applyStimulus(3'b001, 32'h302, 32'h0000BEEF, 32'h11223344, 3, 0);
        checkOutput("sh2_rd", rdCycles, 4);
        checkOutput("sh2_overlap", {31'b0, overlap}, 32'd0);
        checkOutput("sh2_addr", wrAddr, 32'h300);
        checkOutput("sh2_wdata", wrData, 32'hBEEF3344);
        checkOutput("sh2_be", {28'b0, wrBe}, 32'hC);
        checkOutput("sh2_done_cyc", doneCycle, 6);

        applyStimulus(3'b001, 32'h300, 32'h0000BEEF, 32'h11223344, 0, 0);
        checkOutput("sh0_wdata", wrData, 32'h1122BEEF);
        checkOutput("sh0_be", {28'b0, wrBe}, 32'h3);

        applyStimulus(3'b000, 32'h104, 32'hCAFEF00D, 32'h0, 0, 2);
        checkOutput("swwait_wr", wrCycles, 3);
        checkOutput("swwait_done_cyc", doneCycle, 4);

        applyStimulus(3'b000, 32'h102, 32'h12345678, 32'h0, 0, 0);
        checkOutput("esw_done_cyc", doneCycle, 1);
        checkOutput("esw_err", {31'b0, errSeen}, 32'd1);
        checkOutput("esw_strobes", rdCycles + wrCycles, 0);
        checkOutput("esw_ready_cyc", readyCycle, 2);

        applyStimulus(3'b001, 32'h101, 32'h12345678, 32'h0, 0, 0);
        checkOutput("esh_done_cyc", doneCycle, 1);
        checkOutput("esh_err", {31'b0, errSeen}, 32'd1);
        checkOutput("esh_strobes", rdCycles + wrCycles, 0);

        applyStimulus(3'b101, 32'h100, 32'h12345678, 32'h0, 0, 0);
        checkOutput("eop_done_cyc", doneCycle, 1);
        checkOutput("eop_err", {31'b0, errSeen}, 32'd1);
        checkOutput("eop_strobes", rdCycles + wrCycles, 0);

        // Abort a write that memory never acknowledges.
        wrWait   = 1000;
        reqOp    = 3'b000;
        reqAddr  = 32'h400;
        reqData  = 32'h55AA55AA;
        reqValid = 1'b1;
        @(posedge clk); #1;
        reqValid = 1'b0;
        checkOutput("abort_in_wr", {31'b0, memWr}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort_wr_drop", {31'b0, memWr}, 32'd0);
        checkOutput("abort_ready", {31'b0, reqReady}, 32'd1);
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        checkOutput("abort_no_done", dones, 0);

        applyStimulus(3'b000, 32'h404, 32'h0BADF00D, 32'h0, 0, 0);
        checkOutput("post_abort_wdata", wrData, 32'h0BADF00D);
        checkOutput("post_abort_done_cyc", doneCycle, 2);

        // Request held valid continuously: one accept every three cycles.
        reqOp    = 3'b000;
        reqAddr  = 32'h500;
        reqData  = 32'h01020304;
        wrWait   = 0;
        reqValid = 1'b1;
        accepts    = 0;
        dones      = 0;
        lastAccept = -3;
        gapBad     = 1'b0;
        for (int s = 0; s < 12; s++) begin
            if (reqValid && reqReady) begin
                if (s - lastAccept != 3) gapBad = 1'b1;
                lastAccept = s;
                accepts++;
            end
            if (done) dones++;
            @(posedge clk); #1;
        end
        reqValid = 1'b0;
        checkOutput("b2b_accepts", accepts, 4);
        checkOutput("b2b_gap", {31'b0, gapBad}, 32'd0);
        checkOutput("b2b_dones", dones, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/mem_store_merge.md
# mem_store_merge

Store-side counterpart of the load data extender in the multicycle MIPS datapath. It accepts one store request (SW/SH/SB) at a time from the control FSM and checks alignment. Byte and halfword stores are turned into a read-modify-write sequence against the word-only data memory, which has no byte enables. It then reports completion or an alignment/opcode error back to the controller.

## Interface
- AW, 32, byte-address width of req_addr and mem_addr
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready
- req_op  in  3  3'b000 SW, 3'b001 SH, 3'b010 SB, others illegal
- req_addr  in  AW  byte address
- req_data  in  32  store data; SH uses [15:0], SB uses [7:0]
- done  out  1  one-cycle pulse, request finished (success or error)
- err  out  1  valid with done; 1 = misaligned or illegal op, no memory write occurred
- mem_addr  out  AW  word address, {addr_q[AW-1:2], 2'b00}, stable from accept through RESP
- mem_rd  out  1  read strobe, held until mem_rvalid
- mem_rdata  in  32  read data, sampled when mem_rvalid
- mem_rvalid  in  1  read data valid
- mem_wr  out  1  write strobe, held until mem_wack
- mem_wdata  out  32  merged write word, stable while mem_wr
- mem_wack  in  1  write accepted
- mem_be  out  4  lanes being modified (diagnostic); SW 4'b1111, SH 4'b0011/4'b1100, SB one-hot lane

## Operation
- States: IDLE, RD, WR, RESP. Op, addr, data are latched into op_q, addr_q, data_q on accept.
- IDLE: on accept, the next state is chosen as follows.
  - RESP with err=1 if the op is illegal, or SW with addr[1:0]!=0, or SH with addr[0]!=0.
  - Else WR for SW, with mem_wdata = req_data.
  - Else RD for SH/SB.
- RD: mem_rd=1. On mem_rvalid, the merged word is registered into mem_wdata and the state goes to WR.
  - SH, addr_q[1]=1: {data_q[15:0], mem_rdata[15:0]}.
  - SH, addr_q[1]=0: {mem_rdata[31:16], data_q[15:0]}.
  - SB, lane k=addr_q[1:0]: mem_rdata with bits [8k+7:8k] replaced by data_q[7:0].
- WR: mem_wr=1. On mem_wack the state goes to RESP.
- RESP: done=1, err as determined at accept; then the state goes to IDLE.
- mem_rd and mem_wr are never high in the same cycle. No new request is accepted outside IDLE.
- mem_be is decoded from op_q/addr_q and is valid from the cycle after accept through RESP.

## Timing
- Reset (rst high at an edge): state=IDLE, done=0, err=0, mem_rd=0, mem_wr=0, mem_wdata=0, mem_be=0, mem_addr=0. After that edge, req_ready=1.
- Reset mid-operation aborts at that edge. mem_rd/mem_wr drop the following cycle and no done pulse is produced. Late mem_rvalid/mem_wack are ignored in IDLE.
- Accept at edge 0 (cycle 0 ends). With zero-wait memory (rvalid/wack high in the first strobe cycle):
  - SW: WR in cycle 1, RESP/done in cycle 2, req_ready in cycle 3; total 3 cycles.
  - SH/SB: RD in cycle 1, WR in cycle 2, RESP in cycle 3, req_ready in cycle 4.
  - Error: RESP in cycle 1, req_ready in cycle 2.
- Each cycle of mem_rvalid/mem_wack delay adds exactly one cycle. Strobes remain asserted with constant mem_addr/mem_wdata.
- mem_rvalid outside RD and mem_wack outside WR are ignored.
- done is high for exactly one cycle per accepted request.

## Test plan
- SW at 0x100, data 0xDEADBEEF, zero-wait memory: mem_rd never high; mem_wr in cycle 1 with mem_addr 0x100, mem_wdata 0xDEADBEEF, mem_be 4'b1111; done=1, err=0 in cycle 2.
- SB at 0x203, data 0x000000AA, mem_rdata 0x11223344: mem_rd then mem_wr at 0x200 with wdata 0xAA223344, mem_be 4'b1000; repeat for lanes 0..2, giving 0x112233AA, 0x1122AA44, 0x11AA3344.
- SH at 0x302, data 0x0000BEEF, mem_rdata 0x11223344 after 3 wait cycles: mem_rd high 4 cycles, wdata 0xBEEF3344, mem_be 4'b1100; SH at 0x300 gives 0x1122BEEF.
- SW at 0x102, SH at 0x101, op 3'b101: each gives done=1, err=1 one cycle after accept; mem_rd/mem_wr never asserted.
- rst asserted during WR with mem_wack held low: next cycle mem_wr=0, req_ready=1, no done; a subsequent SW completes normally.
- Back-to-back SW requests with req_valid held high: accepts every 3 cycles and never during RD/WR/RESP.
